// File: rtl/seq_mul_div_if.sv
// Request/result bundle for seq_mul_div: operands and op in, handshake and results out.
// Ports: start/op/a/b from the requester; ready/busy/done, result_lo/result_hi, ovf, dbz back.
// master = requester side, slave = engine side.
interface seq_mul_div_if #(
   parameter int N = 8
);
   logic         start;
   logic         op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [N-1:0] result_lo;
   logic [N-1:0] result_hi;
   logic         ovf;
   logic         dbz;

   modport master (
      output start, op, a, b,
      input  ready, busy, done, result_lo, result_hi, ovf, dbz
   );

   modport slave (
      input  start, op, a, b,
      output ready, busy, done, result_lo, result_hi, ovf, dbz
   );
endinterface

// File: rtl/seq_mul_div.sv
// Multi-cycle N-bit multiplier (shift-add) / restoring divider, one add/sub iteration per clock.
// Latency: done pulses N cycles after the accepting edge (the edge itself for divide by zero).
// Backpressure: start accepted only while ready=1 (IDLE); ignored in CALC and DONE.
// Ports: clk, rst (sync, active-high), bus (seq_mul_div_if.slave): start/op/a/b in,
//        ready/busy/done, result_lo/result_hi, ovf, dbz out.
// Option: define SEQ_MUL_DIV_SIGNED_EN for two's-complement operands (sign fix-up on DONE entry).
module seq_mul_div #(
   parameter int N = 8
) (
   input  logic          clk,
   input  logic          rst,
   seq_mul_div_if.slave  bus
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          op_q, op_d;
   // mul: multiplicand; div: divisor
   logic [N-1:0]  opnd_q, opnd_d;
   // mul: upper product half; div: partial remainder
   logic [N-1:0]  hi_q, hi_d;
   // mul: multiplier shifting out / low product shifting in; div: dividend out / quotient in
   logic [N-1:0]  lo_q, lo_d;

   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [N-1:0]  result_lo_q, result_lo_d;
   logic [N-1:0]  result_hi_q, result_hi_d;
   logic          ovf_q, ovf_d;
   logic          dbz_q, dbz_d;

   logic [N-1:0]  a_mag, b_mag;
   logic          accept;
   logic          div_zero;

   // One iteration of the shared datapath
   logic [N:0]    mul_sum;
   logic [N:0]    div_shift;
   logic [N-1:0]  div_diff;
   logic          div_borrow;
   logic [N-1:0]  it_hi, it_lo;

   // Final result as presented on DONE entry
   logic [N-1:0]  fin_lo, fin_hi;
   logic          fin_ovf;

`ifdef SEQ_MUL_DIV_SIGNED_EN
   logic          sa_q, sa_d;
   logic          sb_q, sb_d;
   logic          mnv_q, mnv_d;   // most-negative / -1 divide
   logic [2*N-1:0] prod_s;

   // Core always sees magnitudes; the most-negative value's magnitude still fits in N unsigned bits
   always_comb begin
      a_mag = bus.a[N-1] ? (~bus.a + 1'b1) : bus.a;
      b_mag = bus.b[N-1] ? (~bus.b + 1'b1) : bus.b;
   end

   always_comb begin
      prod_s = (sa_q ^ sb_q) ? (~{it_hi, it_lo} + 1'b1) : {it_hi, it_lo};
      if (op_q) begin
         fin_lo  = (sa_q ^ sb_q) ? (~it_lo + 1'b1) : it_lo;
         // truncating division: remainder follows the dividend's sign
         fin_hi  = sa_q ? (~it_hi + 1'b1) : it_hi;
         fin_ovf = mnv_q;
      end else begin
         fin_lo  = prod_s[N-1:0];
         fin_hi  = prod_s[2*N-1:N];
         // representable as N-bit signed only if the top N+1 bits are a pure sign extension
         fin_ovf = !((&prod_s[2*N-1:N-1]) || (~|prod_s[2*N-1:N-1]));
      end
   end
`else
   always_comb begin
      a_mag = bus.a;
      b_mag = bus.b;
   end

   always_comb begin
      fin_lo  = it_lo;
      fin_hi  = it_hi;
      fin_ovf = op_q ? 1'b0 : (|it_hi);
   end
`endif

   always_comb begin
      // multiply: add multiplicand into upper half when multiplier LSB set, then shift the 2N-bit pair right
      mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
      // divide: bring in next dividend MSB and trial-subtract the divisor
      div_shift  = {hi_q, lo_q[N-1]};
      div_borrow = (div_shift < {1'b0, opnd_q});
      // only consumed when there is no borrow, where the difference is < divisor and fits in N bits
      div_diff   = div_shift[N-1:0] - opnd_q;
      if (op_q) begin
         it_hi = div_borrow ? div_shift[N-1:0] : div_diff;
         it_lo = {lo_q[N-2:0], ~div_borrow};
      end else begin
         it_hi = mul_sum[N:1];
         it_lo = {mul_sum[0], lo_q[N-1:1]};
      end
   end

   assign accept   = bus.start && ready_q && (state_q == IDLE);
   assign div_zero = bus.op && (bus.b == '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      opnd_d      = opnd_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      result_lo_d = result_lo_q;
      result_hi_d = result_hi_q;
      ovf_d       = ovf_q;
      dbz_d       = dbz_q;
`ifdef SEQ_MUL_DIV_SIGNED_EN
      sa_d        = sa_q;
      sb_d        = sb_q;
      mnv_d       = mnv_q;
`endif

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d = bus.op;
`ifdef SEQ_MUL_DIV_SIGNED_EN
               sa_d  = bus.a[N-1];
               sb_d  = bus.b[N-1];
               mnv_d = bus.op && (bus.a == {1'b1, {(N-1){1'b0}}}) && (&bus.b);
`endif
               if (div_zero) begin
                  // no iterations needed: report straight away
                  state_d     = DONE;
                  result_lo_d = '1;
                  result_hi_d = bus.a;
                  ovf_d       = 1'b0;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = CALC;
                  cnt_d   = CW'(N - 1);
                  hi_d    = '0;
                  opnd_d  = bus.op ? b_mag : a_mag;
                  lo_d    = bus.op ? a_mag : b_mag;
               end
            end
         end
         CALC: begin
            hi_d = it_hi;
            lo_d = it_lo;
            if (cnt_q == '0) begin
               state_d     = DONE;
               result_lo_d = fin_lo;
               result_hi_d = fin_hi;
               ovf_d       = fin_ovf;
               dbz_d       = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d == CALC);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= 1'b0;
         opnd_q      <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_lo_q <= '0;
         result_hi_q <= '0;
         ovf_q       <= 1'b0;
         dbz_q       <= 1'b0;
`ifdef SEQ_MUL_DIV_SIGNED_EN
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         mnv_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         opnd_q      <= opnd_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_lo_q <= result_lo_d;
         result_hi_q <= result_hi_d;
         ovf_q       <= ovf_d;
         dbz_q       <= dbz_d;
`ifdef SEQ_MUL_DIV_SIGNED_EN
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         mnv_q       <= mnv_d;
`endif
      end
   end

   assign bus.ready     = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result_lo = result_lo_q;
   assign bus.result_hi = result_hi_q;
   assign bus.ovf       = ovf_q;
   assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_seq_mul_div.sv
module tb_seq_mul_div;

   localparam int N = 8;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   seq_mul_div_if #(.N(N)) bus ();

   seq_mul_div #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain arithmetic on the operands as the requester sees them
   task automatic model(input logic o, input logic [N-1:0] x, input logic [N-1:0] y,
                        output logic [N-1:0] elo, output logic [N-1:0] ehi,
                        output logic eovf, output logic edbz);
      int p, q, r, sx, sy;
      logic [31:0] v;
      edbz = 1'b0;
      eovf = 1'b0;
      if (o && y == '0) begin
         elo  = '1;
         ehi  = x;
         edbz = 1'b1;
      end else begin
`ifdef SEQ_MUL_DIV_SIGNED_EN
         sx = int'($signed(x));
         sy = int'($signed(y));
         if (!o) begin
            p    = sx * sy;
            v    = p;
            elo  = v[N-1:0];
            ehi  = v[2*N-1:N];
            eovf = (p < -128) || (p > 127);
         end else if (sx == -128 && sy == -1) begin
            elo  = 8'h80;
            ehi  = 8'h00;
            eovf = 1'b1;
         end else begin
            q   = sx / sy;
            r   = sx % sy;
            v   = q;
            elo = v[N-1:0];
            v   = r;
            ehi = v[N-1:0];
         end
`else
         sx = int'(x);
         sy = int'(y);
         if (!o) begin
            p    = sx * sy;
            v    = p;
            elo  = v[N-1:0];
            ehi  = v[2*N-1:N];
            eovf = (p > 255);
         end else begin
            q   = sx / sy;
            r   = sx % sy;
            v   = q;
            elo = v[N-1:0];
            v   = r;
            ehi = v[N-1:0];
         end
`endif
      end
   endtask

   // Issue one operation; optionally pulse start with other operands poke_at cycles into it
   task automatic run_op(input string tag, input logic o, input logic [N-1:0] x,
                         input logic [N-1:0] y, input int poke_at);
      logic [N-1:0] elo, ehi;
      logic         eovf, edbz;
      int           lat;
      model(o, x, y, elo, ehi, eovf, edbz);
      check({tag, "_ready"}, 32'(bus.ready), 32'd1);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      tick();
      // scramble the operand pins: the engine must have captured them already
      bus.start = 1'b0;
      bus.op    = 1'($urandom);
      bus.a     = N'($urandom);
      bus.b     = N'($urandom);
      lat = 0;
      while (!bus.done && lat < 40) begin
         bus.start = (lat == poke_at);
         tick();
         lat++;
      end
      bus.start = 1'b0;
      check({tag, "_lat"}, 32'(lat + 1), edbz ? 32'd1 : 32'(N + 1));
      check({tag, "_lo"}, 32'(bus.result_lo), 32'(elo));
      check({tag, "_hi"}, 32'(bus.result_hi), 32'(ehi));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
      check({tag, "_dbz"}, 32'(bus.dbz), 32'(edbz));
      tick();
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_hold"}, {bus.result_hi, bus.result_lo}, {16'd0, ehi, elo});
   endtask

   initial begin
      int seen;
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      tick();
      tick();
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_res", {bus.result_hi, bus.result_lo, 6'd0, bus.ovf, bus.dbz}, 32'd0);
      rst = 1'b0;
      tick();

      run_op("mul13x11", 1'b0, 8'd13, 8'd11, -1);
      run_op("mulFFxFF", 1'b0, 8'hFF, 8'hFF, -1);
      run_op("div200_7", 1'b1, 8'd200, 8'd7, -1);
      run_op("div5_0", 1'b1, 8'd5, 8'd0, -1);
      run_op("mul_poke", 1'b0, 8'd13, 8'd11, 3);
      run_op("div_poke", 1'b1, 8'd250, 8'd9, 5);
      run_op("div_small", 1'b1, 8'd3, 8'd200, -1);
      run_op("mul_zero", 1'b0, 8'd0, 8'hA5, -1);
`ifdef SEQ_MUL_DIV_SIGNED_EN
      run_op("smul_m7x3", 1'b0, 8'hF9, 8'd3, -1);
      run_op("sdiv_m7_2", 1'b1, 8'hF9, 8'd2, -1);
      run_op("sdiv_mn_m1", 1'b1, 8'h80, 8'hFF, -1);
`endif

      // abort mid-calculation; previous results are nonzero so the clear is visible
      run_op("pre_rst", 1'b0, 8'hC3, 8'h77, -1);
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.a     = 8'd99;
      bus.b     = 8'd77;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      check("mid_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ready", 32'(bus.ready), 32'd1);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_res", {bus.result_hi, bus.result_lo, 6'd0, bus.ovf, bus.dbz}, 32'd0);
      seen = 0;
      for (int i = 0; i < 2 * N + 2; i++) begin
         if (bus.done) seen++;
         tick();
      end
      check("abort_no_done", 32'(seen), 32'd0);

      for (int i = 0; i < 40; i++) begin
         run_op("rand", 1'($urandom), N'($urandom), N'($urandom_range(0, 255)), -1);
      end
      // divisor of zero and small divisors drawn deliberately
      for (int i = 0; i < 8; i++) begin
         run_op("rand_div", 1'b1, N'($urandom), N'($urandom_range(0, 3)), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
